tmds_word_scheduler: RTL
========================

TMDS_WORD_SCHEDULER -- requirements
Module: tmds_word_scheduler

Interface
REQ-001 Parameter IDLE_TOKEN, default 10'b1101010100, word sent when no data is scheduled (TMDS control token C1C0=00).
REQ-002 Parameter TRAIN_A, default 10'b1101001100, first word of the training pair.
REQ-003 Parameter TRAIN_B, default 10'b0010110011, second word of the training pair.
REQ-004 clk_5x  input  1  serializer clock, 5 cycles per 10-bit word slot.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 i_enable  input  1  1 = run mode requested; 0 = idle mode requested.
REQ-007 i_train  input  1  1 = training mode requested; overrides i_enable.
REQ-008 i_word_valid  input  1  upstream word valid.
REQ-009 i_word  input  10  upstream TMDS-encoded word.
REQ-010 o_word_ready  output  1  word is accepted when i_word_valid & o_word_ready at a rising edge.
REQ-011 o_par_data  output  10  word driven to the serializer's parallel input.
REQ-012 o_par_load  output  1  one-cycle strobe marking the first cycle of a new word slot.
REQ-013 o_underflow  output  1  one-cycle pulse; run-mode slot filled with IDLE_TOKEN because the FIFO was empty.
REQ-014 o_level  output  3  current FIFO occupancy, 0..4.
REQ-015 o_state  output  2  FSM state: 00 IDLE, 01 TRAIN, 10 RUN.

Function
REQ-016 The block SHALL contain a 4-entry FIFO and a 3-bit phase counter counting 0,1,2,3,4,0,...
REQ-017 The slot boundary SHALL be the edge on which phase goes from 4 to 0; o_par_load SHALL be 1 exactly in the cycle with phase==0.
REQ-018 o_par_data SHALL change only at slot boundaries and SHALL hold its value for all 5 cycles of the slot.
REQ-019 FSM next state, evaluated at each slot boundary with the request inputs sampled on that edge: i_train=1 -> TRAIN; else i_enable=1 -> RUN; else -> IDLE.
REQ-020 The state SHALL NOT change between slot boundaries; requests that are shorter than a slot and not present at a boundary SHALL be ignored.
REQ-021 Word selection at a boundary SHALL use the new state: IDLE -> IDLE_TOKEN; TRAIN -> TRAIN_A, TRAIN_B alternating, starting with TRAIN_A on each TRAIN entry; RUN -> FIFO head if o_level>0, else IDLE_TOKEN.
REQ-022 RUN with an empty FIFO at a boundary SHALL send IDLE_TOKEN and pulse o_underflow in the same cycle as o_par_load.
REQ-023 A FIFO pop SHALL occur only at a RUN boundary with o_level>0; words SHALL leave in arrival order.
REQ-024 o_word_ready SHALL equal (o_level<4) & i_enable & ~i_train.
REQ-025 A push and a pop on the same edge SHALL leave o_level unchanged.
REQ-026 A word pushed on the same edge as an empty-FIFO boundary SHALL NOT be sent in that slot. That slot SHALL carry IDLE_TOKEN with o_underflow, and the word SHALL be sent at the next boundary.
REQ-027 When the state enters IDLE or TRAIN, the FIFO SHALL be flushed (o_level=0) on that boundary edge, and any same-edge push SHALL be discarded.
REQ-028 The FIFO SHALL have no overflow path: writes when o_level==4 are impossible because o_word_ready is 0.

Reset
REQ-029 While rst=1: phase=0, state IDLE, o_par_data=IDLE_TOKEN, o_par_load=0, o_underflow=0, o_level=0, o_word_ready=0, TRAIN toggle=A.
REQ-030 After rst falls, the first o_par_load SHALL occur on the 5th rising edge.
REQ-031 Reset asserted mid-slot SHALL take effect immediately, and queued words SHALL be lost.

Verification
REQ-032 Reset, i_enable=0, run 20 cycles -> o_par_load every 5th cycle, o_par_data=10'b1101010100 throughout, o_underflow never 1.
REQ-033 Push 10'b1101001100, 10'b0110011001, 10'b1010101010 (back-to-back) with i_enable=1 -> the words appear in order on consecutive slots, then IDLE_TOKEN with a single o_underflow pulse.
REQ-034 Hold i_word_valid=1 with i_enable=1 from reset -> o_level reaches 4, o_word_ready drops, and then ready re-rises for one push per slot (o_level oscillates 3/4).
REQ-035 In RUN with o_level=3, set i_train=1 mid-slot -> current word completes, then TRAIN_A, TRAIN_B, TRAIN_A, ... at successive loads; o_level=0 at the boundary.
REQ-036 Push a word on exactly the empty-FIFO RUN boundary edge -> that slot carries IDLE_TOKEN with o_underflow=1, and the next slot carries the pushed word.
REQ-037 Assert rst at phase 2 with o_level=2 -> all outputs take their reset values without waiting for a clock edge; after release, first load after 5 edges carries IDLE_TOKEN.

Source files
------------

// File: rtl/tmds_word_scheduler.sv
// Feeds a 10:1 TMDS serializer: one 10-bit word per 5-cycle slot, chosen from
// idle tokens, a training pair, or a 4-deep FIFO of upstream words.
module tmds_word_scheduler #(
  parameter logic [9:0] IDLE_TOKEN = 10'b1101010100,
  parameter logic [9:0] TRAIN_A    = 10'b1101001100,
  parameter logic [9:0] TRAIN_B    = 10'b0010110011
) (
  input  logic       clk_5x,
  input  logic       rst,
  input  logic       i_enable,
  input  logic       i_train,
  input  logic       i_word_valid,
  input  logic [9:0] i_word,
  output logic       o_word_ready,
  output logic [9:0] o_par_data,
  output logic       o_par_load,
  output logic       o_underflow,
  output logic [2:0] o_level,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRAIN = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [2:0] phase;
  logic [2:0] level;
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic [9:0] mem [0:3];
  logic       train_b;
  logic       boundary;
  logic       push;
  logic       pop;
  logic       flush;

  // Handshake: a word transfers on a rising edge where i_word_valid and
  // o_word_ready are both 1; ready never depends on valid.
  assign o_word_ready = ~rst & (level < 3'd4) & i_enable & ~i_train;
  assign boundary     = (phase == 3'd4);
  assign push         = i_word_valid & o_word_ready;
  assign pop          = boundary & (next_state == ST_RUN) & (level != 3'd0);
  assign flush        = boundary & (next_state != ST_RUN);
  assign o_level      = level;
  assign o_state      = state;

  always_comb begin
    next_state = ST_IDLE;
    if (i_train)       next_state = ST_TRAIN;
    else if (i_enable) next_state = ST_RUN;
  end

  always_ff @(posedge clk_5x) begin
    if (push) mem[wr_ptr] <= i_word;
  end

  always_ff @(posedge clk_5x or posedge rst) begin
    if (rst) begin
      phase       <= 3'd0;
      state       <= ST_IDLE;
      level       <= 3'd0;
      rd_ptr      <= 2'd0;
      wr_ptr      <= 2'd0;
      train_b     <= 1'b0;
      o_par_data  <= IDLE_TOKEN;
      o_par_load  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      phase       <= boundary ? 3'd0 : phase + 3'd1;
      o_par_load  <= boundary;
      o_underflow <= boundary & (next_state == ST_RUN) & (level == 3'd0);

      // Leaving run mode drops everything queued, including a same-edge push.
      if (flush) begin
        level  <= 3'd0;
        rd_ptr <= 2'd0;
        wr_ptr <= 2'd0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 2'd1;
        if (pop)  rd_ptr <= rd_ptr + 2'd1;
        level <= level + {2'b00, push} - {2'b00, pop};
      end

      if (boundary) begin
        state <= next_state;
        case (next_state)
          ST_TRAIN: begin
            if (state != ST_TRAIN) begin
              o_par_data <= TRAIN_A;
              train_b    <= 1'b1;
            end else begin
              o_par_data <= train_b ? TRAIN_B : TRAIN_A;
              train_b    <= ~train_b;
            end
          end
          ST_RUN:  o_par_data <= (level != 3'd0) ? mem[rd_ptr] : IDLE_TOKEN;
          default: o_par_data <= IDLE_TOKEN;
        endcase
      end
    end
  end

endmodule
